// File: rtl/ucsbece154_icache_defs_pkg.sv
// rtl/ucsbece154_icache_defs_pkg.sv - shared icache defaults, refill state encoding, line-align helper
// Shared by the icache refill controller, the cache array and the memory model.
package ucsbece154_icache_defs;

  localparam int BLOCK_WORDS_DEF = 4;
  localparam int OFFSET_BITS_DEF = 2 + $clog2(BLOCK_WORDS_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_COOLDOWN
  } state_t;

  // Clears the byte-offset bits so the address points at word 0 of its line.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_bits);
    return addr & ~((32'd1 << offset_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/ucsbece154_refill_buffer.sv
// rtl/ucsbece154_refill_buffer.sv - BLOCK_WORDS x 32 line assembly buffer with write bypass
// The word being written this cycle is visible on o_line/o_rd_data in the same cycle.
module ucsbece154_refill_buffer
  import ucsbece154_icache_defs::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_we,
  input  logic [$clog2(BLOCK_WORDS)-1:0] i_idx,
  input  logic [31:0]                 i_data,
  input  logic [$clog2(BLOCK_WORDS)-1:0] i_rd_idx,
  output logic [32*BLOCK_WORDS-1:0]   o_line,
  output logic [31:0]                 o_rd_data
);

  localparam int IDXW = $clog2(BLOCK_WORDS);

  logic [31:0] r_slot [BLOCK_WORDS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        r_slot[k] <= '0;
      end
    end else if (i_we) begin
      r_slot[i_idx] <= i_data;
    end
  end

  always_comb begin
    o_line = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      o_line[32*k +: 32] = (i_we && (i_idx == IDXW'(k))) ? i_data : r_slot[k];
    end
  end

  assign o_rd_data = o_line[{i_rd_idx, 5'b00000} +: 32];

endmodule

// File: rtl/ucsbece154_icache_refill.sv
// rtl/ucsbece154_icache_refill.sv - icache miss/refill controller on the SDRAM read-burst port
// Optional feature macro: UCSBECE154_EARLY_RESTART_EN (forward missed word as soon as it arrives).
module ucsbece154_icache_refill
  import ucsbece154_icache_defs::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int OFFSET_BITS = 2 + $clog2(BLOCK_WORDS)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_MissValid,
  input  logic [31:0]               i_MissAddress,
  output logic                      o_MissReady,
  output logic                      o_ReadRequest,
  output logic [31:0]               o_ReadAddress,
  input  logic [31:0]               i_DataIn,
  input  logic                      i_DataReady,
  output logic                      o_LineWe,
  output logic [31:0]               o_LineAddress,
  output logic [32*BLOCK_WORDS-1:0] o_LineData,
  output logic                      o_FetchValid,
  output logic [31:0]               o_FetchWord,
  output logic                      o_Busy,
  output logic                      o_ProtocolError
);

  localparam int IDXW = $clog2(BLOCK_WORDS);
  localparam int CNTW = IDXW + 1;

  state_t                   r_state;
  logic [CNTW-1:0]          r_cnt;
  logic [IDXW-1:0]          r_offset;

  logic                     w_buf_we;
  logic                     w_last;
  logic [31:0]              w_miss_line;
  logic [32*BLOCK_WORDS-1:0] w_line;
  logic [31:0]              w_rd_data;

  assign w_buf_we    = (r_state == S_WAIT) && i_DataReady;
  assign w_last      = w_buf_we && (r_cnt == CNTW'(BLOCK_WORDS - 1));
  assign w_miss_line = line_align(i_MissAddress, OFFSET_BITS);
  assign o_MissReady = (r_state == S_IDLE);
  assign o_Busy      = (r_state != S_IDLE);

  ucsbece154_refill_buffer #(
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_buf (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_we     (w_buf_we),
    .i_idx    (r_cnt[IDXW-1:0]),
    .i_data   (i_DataIn),
    .i_rd_idx (r_offset),
    .o_line   (w_line),
    .o_rd_data(w_rd_data)
  );

  // Pulsed outputs are set on the edge that enters their state, so they are high during it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_offset        <= '0;
      o_ReadRequest   <= 1'b0;
      o_ReadAddress   <= '0;
      o_LineWe        <= 1'b0;
      o_LineAddress   <= '0;
      o_LineData      <= '0;
      o_FetchValid    <= 1'b0;
      o_FetchWord     <= '0;
      o_ProtocolError <= 1'b0;
    end else begin
      o_ReadRequest <= 1'b0;
      o_LineWe      <= 1'b0;
      o_FetchValid  <= 1'b0;
      if (i_DataReady && (r_state != S_WAIT)) begin
        o_ProtocolError <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_MissValid) begin
            r_offset      <= i_MissAddress[OFFSET_BITS-1:2];
            o_ReadAddress <= w_miss_line;
            o_ReadRequest <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_buf_we) begin
            r_cnt <= r_cnt + CNTW'(1);
`ifdef UCSBECE154_EARLY_RESTART_EN
            if (r_cnt[IDXW-1:0] == r_offset) begin
              o_FetchValid <= 1'b1;
              o_FetchWord  <= w_rd_data;
            end
`endif
          end
          if (w_last) begin
            o_LineWe      <= 1'b1;
            o_LineAddress <= o_ReadAddress;
            o_LineData    <= w_line;
`ifndef UCSBECE154_EARLY_RESTART_EN
            o_FetchValid  <= 1'b1;
            o_FetchWord   <= w_rd_data;
`endif
            r_state       <= S_FILL;
          end
        end
        S_FILL: begin
          r_state <= S_COOLDOWN;
        end
        S_COOLDOWN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache_refill.sv
// tb/tb_ucsbece154_icache_refill.sv - self-checking bench for the icache refill controller
// Memory model holds mem[i]=0x13+i and returns bursts with random latency and gaps.
module tb_ucsbece154_icache_refill;

  localparam int BW = 4;

  logic          i_clk;
  logic          i_reset;
  logic          i_MissValid;
  logic [31:0]   i_MissAddress;
  logic          o_MissReady;
  logic          o_ReadRequest;
  logic [31:0]   o_ReadAddress;
  logic [31:0]   i_DataIn;
  logic          i_DataReady;
  logic          o_LineWe;
  logic [31:0]   o_LineAddress;
  logic [32*BW-1:0] o_LineData;
  logic          o_FetchValid;
  logic [31:0]   o_FetchWord;
  logic          o_Busy;
  logic          o_ProtocolError;

  ucsbece154_icache_refill #(.BLOCK_WORDS(BW)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_MissValid    (i_MissValid),
    .i_MissAddress  (i_MissAddress),
    .o_MissReady    (o_MissReady),
    .o_ReadRequest  (o_ReadRequest),
    .o_ReadAddress  (o_ReadAddress),
    .i_DataIn       (i_DataIn),
    .i_DataReady    (i_DataReady),
    .o_LineWe       (o_LineWe),
    .o_LineAddress  (o_LineAddress),
    .o_LineData     (o_LineData),
    .o_FetchValid   (o_FetchValid),
    .o_FetchWord    (o_FetchWord),
    .o_Busy         (o_Busy),
    .o_ProtocolError(o_ProtocolError)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // memory model state (written only by the memory process)
  logic [31:0] mem_q[$];
  int  delay = 0;
  int  widx = 0;
  int  dr_cyc [BW];
  int  last_word_cyc = 0;
  int  words_sent = 0;
  int  req_count = 0;
  int  req_cyc_last = 0;
  bit  prev_req = 0;
  bit  consec_seen = 0;
  int  flush_done = 0;
  int  inj_done = 0;
  // requests from the main sequence
  int  flush_req = 0;
  int  inj_req = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return 32'h13 + idx;
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] la);
    logic [127:0] l;
    for (int k = 0; k < BW; k++) l[32*k +: 32] = mem_word((la >> 2) + k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  initial begin
    i_DataReady = 1'b0;
    i_DataIn    = '0;
    forever begin
      @(negedge i_clk);
      if (flush_req != flush_done) begin
        mem_q.delete();
        delay = 0;
        prev_req = 0;
        flush_done = flush_req;
      end
      i_DataReady = 1'b0;
      i_DataIn    = '0;
      if (inj_req != inj_done) begin
        inj_done    = inj_req;
        i_DataReady = 1'b1;
        i_DataIn    = 32'hDEAD0000;
      end else if (mem_q.size() > 0) begin
        if (delay > 0) delay--;
        else if ($urandom_range(0, 3) != 0) begin
          i_DataIn    = mem_q.pop_front();
          i_DataReady = 1'b1;
          dr_cyc[widx] = cyc;
          widx++;
          words_sent++;
          if (mem_q.size() == 0) last_word_cyc = cyc;
        end
      end
      if (o_ReadRequest) begin
        if (prev_req) consec_seen = 1;
        req_count++;
        req_cyc_last = cyc;
        for (int k = 0; k < BW; k++) mem_q.push_back(mem_word((o_ReadAddress >> 2) + k));
        delay = $urandom_range(0, 2);
        widx = 0;
      end
      prev_req = o_ReadRequest;
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_MissReady && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, o_MissReady, 1'b1);
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp_la,
                         input logic [31:0] exp_fw, input logic [127:0] exp_line, input string tag);
    int lw = 0, fv = 0, lc = 0, fc = 0, r0, exp_fc;
    logic [31:0] la = '0, fw = '0;
    logic [127:0] ld = '0;
    logic mr1 = 1'b1, mr2 = 1'b0;
    wait_ready(tag);
    r0 = req_count;
    i_MissValid = 1'b1;
    i_MissAddress = addr;
    tick();
    i_MissValid = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (o_FetchValid) begin fv++; fw = o_FetchWord; fc = cyc; end
      if (o_LineWe) begin lw++; lc = cyc; la = o_LineAddress; ld = o_LineData; end
      if (lw > 0 && cyc == lc + 1) mr1 = o_MissReady;
      if (lw > 0 && cyc == lc + 2) begin mr2 = o_MissReady; break; end
      tick();
    end
`ifdef UCSBECE154_EARLY_RESTART_EN
    exp_fc = dr_cyc[(addr >> 2) % BW] + 1;
`else
    exp_fc = lc;
`endif
    chk({tag, "_linewe_count"}, lw, 1);
    chk({tag, "_line_addr"}, la, exp_la);
    chk({tag, "_line_data"}, ld, exp_line);
    chk({tag, "_fetch_count"}, fv, 1);
    chk({tag, "_fetch_word"}, fw, exp_fw);
    chk({tag, "_linewe_latency"}, lc, last_word_cyc + 1);
    chk({tag, "_fetch_cycle"}, fc, exp_fc);
    chk({tag, "_req_count"}, req_count - r0, 1);
    chk({tag, "_ready_cooldown"}, mr1, 1'b0);
    chk({tag, "_ready_return"}, mr2, 1'b1);
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic [31:0]  laddr;
    logic [31:0]  fetch;
    logic [127:0] line;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    int n, r0, rc2, wcount;
    int lcs[2];
    logic [31:0] las[2];
    logic [127:0] lds[2];

    vecs[0] = '{32'h00000024, 32'h00000020, 32'h0000001C, {32'h1E, 32'h1D, 32'h1C, 32'h1B}};
    vecs[1] = '{32'h0000003C, 32'h00000030, 32'h00000022, {32'h22, 32'h21, 32'h20, 32'h1F}};
    vecs[2] = '{32'h00000004, 32'h00000000, 32'h00000014, {32'h16, 32'h15, 32'h14, 32'h13}};
    vecs[3] = '{32'h00000040, 32'h00000040, 32'h00000023, {32'h26, 32'h25, 32'h24, 32'h23}};

    i_reset = 1'b1;
    i_MissValid = 1'b0;
    i_MissAddress = '0;
    repeat (3) tick();
    chk("reset_line", o_LineData, '0);
    chk("reset_misc", {o_ReadRequest, o_ReadAddress, o_LineWe, o_LineAddress, o_FetchValid,
                       o_FetchWord, o_Busy, o_ProtocolError}, '0);
    chk("reset_ready", o_MissReady, 1'b1);
    i_reset = 1'b0;
    tick();

    for (int v = 0; v < 3; v++)
      do_miss(vecs[v].addr, vecs[v].laddr, vecs[v].fetch, vecs[v].line, $sformatf("vec%0d", v));

    // MissValid held across two misses: the second must wait for cooldown
    wait_ready("b2b");
    r0 = req_count;
    rc2 = 0;
    n = 0;
    i_MissValid = 1'b1;
    i_MissAddress = 32'h00000104;
    tick();
    i_MissAddress = 32'h00000208;
    for (int t = 0; t < 150; t++) begin
      if (o_LineWe && n < 2) begin lcs[n] = cyc; las[n] = o_LineAddress; lds[n] = o_LineData; n++; end
      if (req_count - r0 == 2 && i_MissValid) begin rc2 = req_cyc_last; i_MissValid = 1'b0; end
      if (n == 2 && cyc == lcs[1] + 2) break;
      tick();
    end
    i_MissValid = 1'b0;
    chk("b2b_linewe_count", n, 2);
    chk("b2b_req_count", req_count - r0, 2);
    chk("b2b_addr0", las[0], 32'h00000100);
    chk("b2b_addr1", las[1], 32'h00000200);
    chk("b2b_line0", lds[0], model_line(32'h00000100));
    chk("b2b_line1", lds[1], model_line(32'h00000200));
    chk("b2b_req_gap", rc2 - lcs[0], 3);

    // reset after the second DataReady of a burst
    wait_ready("mid");
    wcount = words_sent;
    i_MissValid = 1'b1;
    i_MissAddress = 32'h00000084;
    tick();
    i_MissValid = 1'b0;
    n = 0;
    while (words_sent < wcount + 2 && n < 50) begin tick(); n++; end
    chk("mid_words", words_sent - wcount, 2);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    flush_req++;
    tick();
    chk("mid_rst_line", o_LineData, '0);
    chk("mid_rst_misc", {o_ReadRequest, o_ReadAddress, o_LineWe, o_LineAddress, o_FetchValid,
                         o_FetchWord, o_Busy, o_ProtocolError}, '0);
    chk("mid_rst_ready", o_MissReady, 1'b1);
    i_reset = 1'b0;
    n = 0;
    for (int t = 0; t < 10; t++) begin
      if (o_LineWe) n++;
      tick();
    end
    chk("mid_no_linewe", n, 0);
    do_miss(vecs[3].addr, vecs[3].laddr, vecs[3].fetch, vecs[3].line, "vec3");

    for (int r = 0; r < 12; r++) begin
      ra = $urandom;
      do_miss(ra, ra & ~32'hF, mem_word(ra >> 2), model_line(ra & ~32'hF), $sformatf("rnd%0d", r));
    end

    chk("no_consecutive_req", consec_seen, 1'b0);

    // DataReady while idle is a protocol error and must not write the cache
    wait_ready("perr");
    chk("perr_before", o_ProtocolError, 1'b0);
    inj_req++;
    tick();
    tick();
    chk("perr_set", o_ProtocolError, 1'b1);
    n = 0;
    for (int t = 0; t < 6; t++) begin
      if (o_LineWe) n++;
      tick();
    end
    chk("perr_no_linewe", n, 0);
    chk("perr_sticky", o_ProtocolError, 1'b1);
    do_miss(32'h00000058, 32'h00000050, mem_word(32'h16), model_line(32'h00000050), "perr_miss");
    chk("perr_still", o_ProtocolError, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
